// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencing controller for the IF/ID and ID/EX registers of a 5-stage pipeline.
// Detects load-use hazards, branch/jump redirects and data-memory waits. Multi-cycle
// penalties are counted down by a small FSM.
// Optional: define HAZARD_PERF_CNT_EN to add the 16-bit stall_cycles counter output.
module pipeline_hazard_ctrl #(
  parameter int unsigned LU_BUBBLES  = 1,
  parameter int unsigned BR_PENALTY  = 1,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       IDEX_MemRd,
  input  logic [4:0] IDEX_Rt,
  input  logic [4:0] IFID_Rs,
  input  logic [4:0] IFID_Rt,
  input  logic       ID_UsesRt,
  input  logic       ID_Jump,
  input  logic       EX_BranchTaken,
  input  logic       mem_busy,
  output logic       PC_Write,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Stall,
  output logic       EXMEM_Hold,
  output logic       mem_err,
  output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuWait  = 2'd1,
    StBrFlush = 2'd2,
    StMemWait = 2'd3
  } state_e;

  localparam logic [7:0] LuInit = 8'(LU_BUBBLES - 1);
  localparam logic [7:0] BrInit = 8'(BR_PENALTY - 1);
  localparam logic [8:0] MemTo  = 9'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       mem_err_q, mem_err_d;
  logic       lu_hit;
  logic       eval_run;
  logic [8:0] count_inc;

  // Register 0 is hardwired zero, so it can never carry a load-use dependency.
  assign lu_hit = IDEX_MemRd && (IDEX_Rt != 5'd0) &&
                  ((IDEX_Rt == IFID_Rs) || (ID_UsesRt && (IDEX_Rt == IFID_Rt)));

  assign count_inc = {1'b0, count_q} + 9'd1;
  assign mem_err   = mem_err_q;
  assign state     = state_q;

  // Next-state, counter and pipeline control outputs.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mem_err_d  = mem_err_q;
    PC_Write   = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Stall = 1'b0;
    EXMEM_Hold = 1'b0;
    eval_run   = 1'b0;

    unique case (state_q)
      StRun: eval_run = 1'b1;
      StLuWait: begin
        if (mem_busy || EX_BranchTaken) begin
          eval_run = 1'b1;  // preemption aborts the remaining bubbles
        end else begin
          PC_Write   = 1'b0;
          IFID_Write = 1'b0;
          IDEX_Stall = 1'b1;
          if (count_q <= 8'd1) begin
            state_d = StRun;
            count_d = 8'd0;
          end else begin
            count_d = count_q - 8'd1;
          end
        end
      end
      StBrFlush: begin
        if (mem_busy) begin
          eval_run = 1'b1;
        end else begin
          IFID_Write = 1'b0;
          IFID_Flush = 1'b1;
          IDEX_Stall = 1'b1;
          if (count_q <= 8'd1) begin
            state_d = StRun;
            count_d = 8'd0;
          end else begin
            count_d = count_q - 8'd1;
          end
        end
      end
      StMemWait: begin
        if (mem_busy) begin
          PC_Write   = 1'b0;
          IFID_Write = 1'b0;
          EXMEM_Hold = 1'b1;
          if (count_inc >= MemTo) begin
            mem_err_d = 1'b1;
            state_d   = StRun;
            count_d   = 8'd0;
          end else begin
            count_d = count_inc[7:0];
          end
        end else begin
          eval_run = 1'b1;  // memory ready: re-evaluate pending hazards as in RUN
        end
      end
      default: eval_run = 1'b1;
    endcase

    if (eval_run) begin
      state_d = StRun;
      count_d = 8'd0;
      if (mem_busy) begin
        PC_Write   = 1'b0;
        IFID_Write = 1'b0;
        EXMEM_Hold = 1'b1;
        if (MemTo <= 9'd1) begin
          mem_err_d = 1'b1;
        end else begin
          state_d = StMemWait;
          count_d = 8'd1;
        end
      end else if (EX_BranchTaken) begin
        IFID_Write = 1'b0;
        IFID_Flush = 1'b1;
        IDEX_Stall = 1'b1;
        if (BR_PENALTY > 1) begin
          state_d = StBrFlush;
          count_d = BrInit;
        end
      end else if (lu_hit) begin
        PC_Write   = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Stall = 1'b1;
        if (LU_BUBBLES > 1) begin
          state_d = StLuWait;
          count_d = LuInit;
        end
      end else if (ID_Jump) begin
        IFID_Write = 1'b0;
        IFID_Flush = 1'b1;
      end
    end

    if (reset) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_Stall = 1'b1;
      EXMEM_Hold = 1'b0;
    end
  end

  // State, counter and sticky error flag with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      count_q   <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mem_err_q <= mem_err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  assign stall_cycles = stall_cnt_q;

  // Saturating count of cycles where the PC is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else if (!PC_Write && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl using two parameterisations.
module tb_pipeline_hazard_ctrl;

  localparam logic [4:0] Norm = 5'b11000;  // {PC_Write, IFID_Write, IFID_Flush, IDEX_Stall, EXMEM_Hold}
  localparam logic [4:0] Lu   = 5'b00010;
  localparam logic [4:0] Brf  = 5'b10110;
  localparam logic [4:0] Jmp  = 5'b10100;
  localparam logic [4:0] Hold = 5'b00001;
  localparam logic [4:0] Rst  = 5'b00110;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       IDEX_MemRd = 1'b0;
  logic [4:0] IDEX_Rt = 5'd0;
  logic [4:0] IFID_Rs = 5'd0;
  logic [4:0] IFID_Rt = 5'd0;
  logic       ID_UsesRt = 1'b0;
  logic       ID_Jump = 1'b0;
  logic       EX_BranchTaken = 1'b0;
  logic       mem_busy = 1'b0;

  logic       a_pc, a_ifw, a_fl, a_st, a_ho, a_err;
  logic       b_pc, b_ifw, b_fl, b_st, b_ho, b_err;
  logic [1:0] a_state, b_state;
  logic [4:0] oa, ob;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] a_stall, b_stall;
`endif

  int checks = 0;
  int errors = 0;

  assign oa = {a_pc, a_ifw, a_fl, a_st, a_ho};
  assign ob = {b_pc, b_ifw, b_fl, b_st, b_ho};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LU_BUBBLES(1), .BR_PENALTY(2), .MEM_TIMEOUT(255)) dut_a (
    .clk(clk), .reset(reset), .IDEX_MemRd(IDEX_MemRd), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
    .EX_BranchTaken(EX_BranchTaken), .mem_busy(mem_busy), .PC_Write(a_pc),
    .IFID_Write(a_ifw), .IFID_Flush(a_fl), .IDEX_Stall(a_st), .EXMEM_Hold(a_ho),
    .mem_err(a_err), .state(a_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(a_stall)
`endif
  );

  pipeline_hazard_ctrl #(.LU_BUBBLES(3), .BR_PENALTY(1), .MEM_TIMEOUT(3)) dut_b (
    .clk(clk), .reset(reset), .IDEX_MemRd(IDEX_MemRd), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
    .EX_BranchTaken(EX_BranchTaken), .mem_busy(mem_busy), .PC_Write(b_pc),
    .IFID_Write(b_ifw), .IFID_Flush(b_fl), .IDEX_Stall(b_st), .EXMEM_Hold(b_ho),
    .mem_err(b_err), .state(b_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(b_stall)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    IDEX_MemRd = 1'b0; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
    ID_UsesRt = 1'b0; ID_Jump = 1'b0; EX_BranchTaken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (oa !== Rst) begin errors++; $display("FAIL reset_out_a got %b want %b", oa, Rst); end
    checks++;
    if (ob !== Rst) begin errors++; $display("FAIL reset_out_b got %b want %b", ob, Rst); end
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_state, a_err, oa} !== {2'd0, 1'b0, Norm}) begin
      errors++; $display("FAIL post_reset_a got %b want %b", {a_state, a_err, oa}, {2'd0, 1'b0, Norm});
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    IDEX_MemRd = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
    @(negedge clk);
    checks++;
    if ({a_state, oa} !== {2'd0, Lu}) begin
      errors++; $display("FAIL lu_rs_a got %b want %b", {a_state, oa}, {2'd0, Lu});
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({a_state, oa} !== {2'd0, Norm}) begin
      errors++; $display("FAIL lu_after_a got %b want %b", {a_state, oa}, {2'd0, Norm});
    end
    tick();
    IDEX_MemRd = 1'b1; IDEX_Rt = 5'd9; IFID_Rt = 5'd9; ID_UsesRt = 1'b1; IFID_Rs = 5'd3;
    @(negedge clk);
    checks++;
    if (oa !== Lu) begin errors++; $display("FAIL lu_rt_a got %b want %b", oa, Lu); end
    tick();
    clear_inputs();
  endtask

  task automatic test_no_hazard();
    do_reset();
    IDEX_MemRd = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0;
    @(negedge clk);
    checks++;
    if (oa !== Norm) begin errors++; $display("FAIL r0_nostall got %b want %b", oa, Norm); end
    tick();
    IDEX_Rt = 5'd9; IFID_Rt = 5'd9; ID_UsesRt = 1'b0; IFID_Rs = 5'd4;
    @(negedge clk);
    checks++;
    if (ob !== Norm) begin errors++; $display("FAIL rt_unused got %b want %b", ob, Norm); end
    tick();
    clear_inputs();
  endtask

  task automatic test_jump();
    do_reset();
    ID_Jump = 1'b1;
    @(negedge clk);
    checks++;
    if (oa !== Jmp) begin errors++; $display("FAIL jump got %b want %b", oa, Jmp); end
    tick();
    ID_Jump = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_state, oa} !== {2'd0, Norm}) begin
      errors++; $display("FAIL jump_after got %b want %b", {a_state, oa}, {2'd0, Norm});
    end
    tick();
  endtask

  task automatic test_branch();
    logic [6:0] exp_a [3];
    logic [4:0] exp_b [3];
    exp_a[0] = {2'd0, Brf}; exp_a[1] = {2'd2, Brf}; exp_a[2] = {2'd0, Norm};
    exp_b[0] = Brf;         exp_b[1] = Norm;        exp_b[2] = Norm;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      EX_BranchTaken = (i == 0);
      @(negedge clk);
      checks++;
      if ({a_state, oa} !== exp_a[i]) begin
        errors++; $display("FAIL branch_a[%0d] got %b want %b", i, {a_state, oa}, exp_a[i]);
      end
      checks++;
      if (ob !== exp_b[i]) begin
        errors++; $display("FAIL branch_b[%0d] got %b want %b", i, ob, exp_b[i]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_branch_vs_lu();
    logic [6:0] exp_b [3];
    exp_b[0] = {2'd0, Lu}; exp_b[1] = {2'd1, Brf}; exp_b[2] = {2'd0, Norm};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      IDEX_MemRd = (i == 0); IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
      EX_BranchTaken = (i == 1);
      @(negedge clk);
      checks++;
      if ({b_state, ob} !== exp_b[i]) begin
        errors++; $display("FAIL br_vs_lu[%0d] got %b want %b", i, {b_state, ob}, exp_b[i]);
      end
      tick();
    end
    // Simultaneous branch and load-use in RUN: branch wins.
    IDEX_MemRd = 1'b1; EX_BranchTaken = 1'b1;
    @(negedge clk);
    checks++;
    if (ob !== Brf) begin errors++; $display("FAIL br_and_lu got %b want %b", ob, Brf); end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({b_state, ob} !== {2'd0, Norm}) begin
      errors++; $display("FAIL br_and_lu_after got %b want %b", {b_state, ob}, {2'd0, Norm});
    end
    tick();
  endtask

  task automatic test_mem_wait();
    logic [1:0] exp_sa [4];
    logic [1:0] exp_sb [4];
    logic       exp_eb [4];
    exp_sa[0] = 2'd0; exp_sa[1] = 2'd3; exp_sa[2] = 2'd3; exp_sa[3] = 2'd3;
    exp_sb[0] = 2'd0; exp_sb[1] = 2'd3; exp_sb[2] = 2'd3; exp_sb[3] = 2'd0;
    exp_eb[0] = 1'b0; exp_eb[1] = 1'b0; exp_eb[2] = 1'b0; exp_eb[3] = 1'b1;
    do_reset();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({a_state, a_err, oa} !== {exp_sa[i], 1'b0, Hold}) begin
        errors++; $display("FAIL memwait_a[%0d] got %b want %b", i, {a_state, a_err, oa},
                           {exp_sa[i], 1'b0, Hold});
      end
      checks++;
      if ({b_state, b_err, ob} !== {exp_sb[i], exp_eb[i], Hold}) begin
        errors++; $display("FAIL memwait_b[%0d] got %b want %b", i, {b_state, b_err, ob},
                           {exp_sb[i], exp_eb[i], Hold});
      end
      tick();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_state, oa} !== {2'd3, Norm}) begin
      errors++; $display("FAIL mem_release_a got %b want %b", {a_state, oa}, {2'd3, Norm});
    end
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({a_state, a_err, b_err} !== {2'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL mem_err_sticky got %b want %b", {a_state, a_err, b_err}, 5'b00001);
    end
    tick();
  endtask

  task automatic test_reset_mid_lu();
    do_reset();
    IDEX_MemRd = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({b_state, ob} !== {2'd1, Lu}) begin
      errors++; $display("FAIL lu_wait_entry got %b want %b", {b_state, ob}, {2'd1, Lu});
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (b_stall !== 16'd1) begin errors++; $display("FAIL perf_cnt got %0d want 1", b_stall); end
`endif
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ob !== Rst) begin errors++; $display("FAIL reset_mid_lu got %b want %b", ob, Rst); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_state, b_err, ob} !== {2'd0, 1'b0, Norm}) begin
      errors++; $display("FAIL after_reset_mid_lu got %b want %b", {b_state, b_err, ob},
                         {2'd0, 1'b0, Norm});
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (b_stall !== 16'd0) begin errors++; $display("FAIL perf_clr got %0d want 0", b_stall); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_jump();
    test_branch();
    test_branch_vs_lu();
    test_mem_wait();
    test_reset_mid_lu();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the IF/ID and ID/EX pipeline registers of the 5-stage MIPS-style pipeline.
- Detects load-use hazards, branch/jump redirects and memory wait conditions.
- Drives PC write enable, IF/ID write/flush, the ID/EX bubble input (Stall of the ID/EX register) and an EX/MEM hold.
- Multi-cycle penalties are sequenced by an internal FSM with a countdown counter.

Parameters:
- LU_BUBBLES, 1, bubbles inserted per load-use hazard (1..7).
- BR_PENALTY, 1, cycles IF/ID is flushed after a taken EX branch (1..3).
- MEM_TIMEOUT, 255, max consecutive mem_busy cycles before mem_err sets (1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- IDEX_MemRd  in  1  instruction in EX is a load.
- IDEX_Rt  in  5  load destination in EX.
- IFID_Rs  in  5  rs of instruction in ID.
- IFID_Rt  in  5  rt of instruction in ID.
- ID_UsesRt  in  1  ID instruction reads rt as a source.
- ID_Jump  in  1  ID decodes j/jal/jr/jalr (PCSrc jump class).
- EX_BranchTaken  in  1  branch in EX resolved taken.
- mem_busy  in  1  data memory not ready this cycle.
- PC_Write  out  1  PC update enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_Flush  out  1  IF/ID clear to nop.
- IDEX_Stall  out  1  ID/EX loads bubble (all-zero data/control).
- EXMEM_Hold  out  1  freeze EX/MEM and MEM/WB.
- mem_err  out  1  sticky memory-timeout flag.
- state  out  2  FSM state (debug).

Behaviour:
- Outputs are combinational from registered state, count and current inputs. State, count and mem_err are registered.
- FSM states: RUN=0, LU_WAIT=1, BR_FLUSH=2, MEM_WAIT=3.
- Reset (synchronous, dominates everything):
  - Next state RUN, count=0, mem_err=0.
  - While reset is high: PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Stall=1, EXMEM_Hold=0.
- Hazard conditions:
  - lu_hit = IDEX_MemRd & IDEX_Rt!=0 & (IDEX_Rt==IFID_Rs | (ID_UsesRt & IDEX_Rt==IFID_Rt)).
  - Register 0 never hazards.
- RUN evaluation, in priority order:
  1. mem_busy: EXMEM_Hold=1, PC_Write=0, IFID_Write=0, IDEX_Stall=0 (ID/EX must also be held; the hold is applied by gating clk-enable upstream). Next MEM_WAIT, count=1.
  2. EX_BranchTaken: IFID_Flush=1, IDEX_Stall=1, PC_Write=1. If BR_PENALTY>1, next BR_FLUSH with count=BR_PENALTY-1.
  3. lu_hit: PC_Write=0, IFID_Write=0, IDEX_Stall=1. If LU_BUBBLES>1, next LU_WAIT with count=LU_BUBBLES-1.
  4. ID_Jump: IFID_Flush=1, PC_Write=1 (one-cycle, stays RUN).
  5. Otherwise: PC_Write=1, IFID_Write=1, all flush/stall/hold=0.
- LU_WAIT:
  - Same outputs as RUN case 3.
  - count decrements each cycle; at count==1 next RUN.
  - mem_busy or EX_BranchTaken preempt exactly as in RUN (branch aborts the remaining bubbles).
- BR_FLUSH:
  - IFID_Flush=1, IDEX_Stall=1, PC_Write=1.
  - count decrements; next RUN at count==1.
  - mem_busy preempts to MEM_WAIT.
- MEM_WAIT:
  - Outputs as RUN case 1 while mem_busy.
  - count increments, saturating at MEM_TIMEOUT.
  - When count reaches MEM_TIMEOUT with mem_busy still high: mem_err<=1 (sticky until reset), then forced return to RUN.
  - When mem_busy falls: next RUN with normal RUN outputs that cycle. Pending hazards are re-evaluated from the inputs.
- Simultaneous EX_BranchTaken and lu_hit: the branch wins. The load-use instruction is being flushed.
- IFID_Flush and IFID_Write are never both 1. Flush has precedence in the IF/ID register.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - Adds output stall_cycles (16 bits).
  - Increments in every cycle where PC_Write==0 and reset==0, saturating at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Load-use, LU_BUBBLES=1: IDEX_MemRd=1, IDEX_Rt=8, IFID_Rs=8 for 1 cycle -> PC_Write=0, IFID_Write=0, IDEX_Stall=1 that cycle. Next cycle (IDEX_MemRd=0) normal RUN outputs, state=0.
- Register-zero and rt-unused: IDEX_Rt=0=IFID_Rs -> no stall. Also IDEX_Rt=9=IFID_Rt with ID_UsesRt=0 -> no stall.
- Branch penalty, BR_PENALTY=2: EX_BranchTaken pulse -> IFID_Flush=1, IDEX_Stall=1 for 2 consecutive cycles, state 0->2->0.
- Branch vs load-use, LU_BUBBLES=3: lu_hit starts LU_WAIT; EX_BranchTaken asserted in 2nd bubble -> flush outputs, remaining bubbles cancelled, state returns to 0.
- Memory wait: mem_busy high 4 cycles -> EXMEM_Hold=1, PC_Write=0 for 4 cycles, state=3, mem_err=0. With MEM_TIMEOUT=3 and mem_busy held -> mem_err=1 after 3rd busy cycle and stays 1 until reset.
- Reset mid-LU_WAIT: reset asserted -> same cycle IFID_Flush=1, IDEX_Stall=1, PC_Write=0. After release, state=0 and (if HAZARD_PERF_CNT_EN) stall_cycles=0.
